// File: rtl/p405s_utlb_pkg.sv
// Shared types for the UTLB access sequencer: FSM states, TLB op codes,
// completion source codes and the arbiter grant vector.
package p405s_utlb_pkg;

  localparam int IDX_W_DEF      = 6;
  localparam int STARVE_LIM_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_COMPARE = 2'd2,
    ST_RESULT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_TLBRE = 2'd0,
    OP_TLBWE = 2'd1,
    OP_TLBSX = 2'd2,
    OP_RSVD  = 2'd3
  } tlb_op_e;

  typedef enum logic [1:0] {
    SRC_ITLB = 2'd0,
    SRC_DTLB = 2'd1,
    SRC_EXE  = 2'd2
  } src_e;

  typedef struct packed {
    logic exe;
    logic dtlb;
    logic itlb;
  } grant_t;

  // ITLB/DTLB misses are latched as tlbsx, so one test covers every CAM access.
  function automatic logic is_lookup(input tlb_op_e op);
    return (op == OP_TLBSX) || (op == OP_RSVD);
  endfunction

endpackage

// File: rtl/p405s_utlb_arb.sv
// Fixed-priority arbiter (exe > DTLB > ITLB) with an ITLB starvation
// counter that forces an ITLB win after STARVE_LIM lost arbitrations.
module p405s_utlb_arb
  import p405s_utlb_pkg::*;
#(
  parameter int STARVE_LIM = STARVE_LIM_DEF,
  parameter int CNT_W      = $clog2(STARVE_LIM + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arb_en_i,
  input  logic             i_req_i,
  input  logic             d_req_i,
  input  logic             exe_req_i,
  output grant_t           grant_o,
  output logic [CNT_W-1:0] starve_cnt_o
);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             starved;

  assign starved = i_req_i && (starve_q == CNT_W'(STARVE_LIM));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_o = '0;
    if (arb_en_i) begin
      if (starved)        grant_o.itlb = 1'b1;
      else if (exe_req_i) grant_o.exe  = 1'b1;
      else if (d_req_i)   grant_o.dtlb = 1'b1;
      else if (i_req_i)   grant_o.itlb = 1'b1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!i_req_i || grant_o.itlb) begin
      starve_d = '0;
    end else if ((grant_o.exe || grant_o.dtlb) && !starved) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end

  assign starve_cnt_o = starve_q;

endmodule

// File: rtl/p405s_utlb_access_seq.sv
// UTLB access sequencer: grants one requester at a time, drives the array
// enables through ACCESS/COMPARE/RESULT and returns a tagged hit/index result.
module p405s_utlb_access_seq
  import p405s_utlb_pkg::*;
#(
  parameter int IDX_W      = IDX_W_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic             CB,
  input  logic             resetN,
  input  logic             iLookupReq,
  input  logic             dLookupReq,
  input  logic             exeTlbReq,
  input  logic [1:0]       exeTlbOp,
  input  logic [IDX_W-1:0] exeTlbIdx,
  input  logic             utlbFlush,
  input  logic             TestM3,
  input  logic             utlbHit,
  input  logic [IDX_W-1:0] utlbHitIdx,
  output logic             iAck,
  output logic             dAck,
  output logic             exeAck,
  output logic             rdEn,
  output logic             wrEn,
  output logic             lookupEn,
  output logic             LookupenForEnC1,
  output logic [IDX_W-1:0] arrayIdx,
  output logic             done,
  output logic [1:0]       doneSrc,
  output logic             resHit,
  output logic [IDX_W-1:0] resIdx,
  output logic             busy
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);

  state_e           state_q, state_d;
  src_e             src_q, src_d;
  tlb_op_e          op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             flush_q, flush_d;

  src_e             done_src_q, done_src_d;
  logic             res_hit_q, res_hit_d;
  logic [IDX_W-1:0] res_idx_q, res_idx_d;

  logic             i_ack_q, d_ack_q, exe_ack_q;
  logic             rd_en_q, wr_en_q, lookup_en_q, c1_en_q;
  logic             done_q, busy_q;
  logic [IDX_W-1:0] array_idx_q;

  logic             access_d, rd_en_d, wr_en_d, lookup_en_d;
  logic [IDX_W-1:0] array_idx_d;

  logic             arb_en;
  grant_t           grant;
  // Kept visible for debug; the sequencer itself only needs the grant.
  logic [CNT_W-1:0] starve_cnt_unused;

  assign arb_en = (state_q == ST_IDLE) && !TestM3;

  p405s_utlb_arb #(
    .STARVE_LIM (STARVE_LIM),
    .CNT_W      (CNT_W)
  ) u_arb (
    .clk          (CB),
    .rst_n        (resetN),
    .arb_en_i     (arb_en),
    .i_req_i      (iLookupReq),
    .d_req_i      (dLookupReq),
    .exe_req_i    (exeTlbReq),
    .grant_o      (grant),
    .starve_cnt_o (starve_cnt_unused)
  );

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    op_d       = op_q;
    idx_d      = idx_q;
    flush_d    = flush_q;
    done_src_d = done_src_q;
    res_hit_d  = res_hit_q;
    res_idx_d  = res_idx_q;
    unique case (state_q)
      ST_IDLE: begin
        flush_d = 1'b0;
        if (grant.exe) begin
          state_d = ST_ACCESS;
          src_d   = SRC_EXE;
          op_d    = tlb_op_e'(exeTlbOp);
          idx_d   = exeTlbIdx;
        end else if (grant.dtlb || grant.itlb) begin
          state_d = ST_ACCESS;
          src_d   = grant.dtlb ? SRC_DTLB : SRC_ITLB;
          op_d    = OP_TLBSX;
          idx_d   = '0;
        end
      end
      ST_ACCESS: begin
        if (is_lookup(op_q)) begin
          state_d = ST_COMPARE;
          if (utlbFlush) flush_d = 1'b1;
        end else begin
          state_d    = ST_RESULT;
          done_src_d = src_q;
          res_hit_d  = 1'b0;
          res_idx_d  = idx_q;
        end
      end
      ST_COMPARE: begin
        // A flush seen in either ACCESS or COMPARE kills the hit but not the done.
        state_d    = ST_RESULT;
        done_src_d = src_q;
        res_hit_d  = utlbHit && !utlbFlush && !flush_q;
        res_idx_d  = utlbHitIdx;
      end
      ST_RESULT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next state so they register alongside it.
  assign access_d    = (state_d == ST_ACCESS);
  assign rd_en_d     = access_d && (op_d == OP_TLBRE);
  assign wr_en_d     = access_d && (op_d == OP_TLBWE);
  assign lookup_en_d = access_d && is_lookup(op_d);
  assign array_idx_d = (rd_en_d || wr_en_d) ? idx_d : '0;

  always_ff @(posedge CB or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      src_q       <= SRC_ITLB;
      op_q        <= OP_TLBRE;
      idx_q       <= '0;
      flush_q     <= 1'b0;
      done_src_q  <= SRC_ITLB;
      res_hit_q   <= 1'b0;
      res_idx_q   <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      exe_ack_q   <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      lookup_en_q <= 1'b0;
      c1_en_q     <= 1'b0;
      array_idx_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      flush_q     <= flush_d;
      done_src_q  <= done_src_d;
      res_hit_q   <= res_hit_d;
      res_idx_q   <= res_idx_d;
      i_ack_q     <= grant.itlb;
      d_ack_q     <= grant.dtlb;
      exe_ack_q   <= grant.exe;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      lookup_en_q <= lookup_en_d;
      c1_en_q     <= (state_d == ST_COMPARE);
      array_idx_q <= array_idx_d;
      done_q      <= (state_d == ST_RESULT);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign iAck            = i_ack_q;
  assign dAck            = d_ack_q;
  assign exeAck          = exe_ack_q;
  assign rdEn            = rd_en_q;
  assign wrEn            = wr_en_q;
  assign lookupEn        = lookup_en_q;
  assign LookupenForEnC1 = c1_en_q;
  assign arrayIdx        = array_idx_q;
  assign done            = done_q;
  assign doneSrc         = done_src_q;
  assign resHit          = res_hit_q;
  assign resIdx          = res_idx_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_p405s_utlb_access_seq.sv
// Directed bench for the UTLB access sequencer: a cycle-by-cycle vector table
// followed by hand-written starvation and mid-operation reset sequences.
module tb_p405s_utlb_access_seq;

  typedef struct packed {
    logic       ireq, dreq, ereq;
    logic [1:0] op;
    logic [5:0] eidx;
    logic       flush, tm3, hit;
    logic [5:0] hidx;
  } in_t;

  typedef struct packed {
    logic       i_ack, d_ack, e_ack;
    logic       rd, wr, lk, c1;
    logic [5:0] aidx;
    logic       done;
    logic [1:0] src;
    logic       hit;
    logic [5:0] ridx;
    logic       busy;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  logic       CB = 1'b0;
  logic       resetN = 1'b0;
  logic       iLookupReq = 1'b0, dLookupReq = 1'b0, exeTlbReq = 1'b0;
  logic [1:0] exeTlbOp = 2'b00;
  logic [5:0] exeTlbIdx = 6'h00;
  logic       utlbFlush = 1'b0, TestM3 = 1'b0, utlbHit = 1'b0;
  logic [5:0] utlbHitIdx = 6'h00;
  logic       iAck, dAck, exeAck, rdEn, wrEn, lookupEn, LookupenForEnC1;
  logic [5:0] arrayIdx, resIdx;
  logic       done, resHit, busy;
  logic [1:0] doneSrc;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  always #5 CB = ~CB;

  p405s_utlb_access_seq dut (
    .CB              (CB),
    .resetN          (resetN),
    .iLookupReq      (iLookupReq),
    .dLookupReq      (dLookupReq),
    .exeTlbReq       (exeTlbReq),
    .exeTlbOp        (exeTlbOp),
    .exeTlbIdx       (exeTlbIdx),
    .utlbFlush       (utlbFlush),
    .TestM3          (TestM3),
    .utlbHit         (utlbHit),
    .utlbHitIdx      (utlbHitIdx),
    .iAck            (iAck),
    .dAck            (dAck),
    .exeAck          (exeAck),
    .rdEn            (rdEn),
    .wrEn            (wrEn),
    .lookupEn        (lookupEn),
    .LookupenForEnC1 (LookupenForEnC1),
    .arrayIdx        (arrayIdx),
    .done            (done),
    .doneSrc         (doneSrc),
    .resHit          (resHit),
    .resIdx          (resIdx),
    .busy            (busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic in_t mi(input logic ir, input logic dr, input logic er, input logic [1:0] op,
                             input logic [5:0] eidx, input logic fl, input logic tm, input logic ht,
                             input logic [5:0] hidx);
    in_t v;
    v.ireq = ir; v.dreq = dr; v.ereq = er; v.op = op; v.eidx = eidx;
    v.flush = fl; v.tm3 = tm; v.hit = ht; v.hidx = hidx;
    return v;
  endfunction

  // ack = {iAck,dAck,exeAck}, en = {rdEn,wrEn,lookupEn}
  function automatic out_t mo(input logic [2:0] ack, input logic [2:0] en, input logic c1,
                              input logic [5:0] aidx, input logic dn, input logic [1:0] src,
                              input logic ht, input logic [5:0] ridx, input logic bsy);
    out_t o;
    {o.i_ack, o.d_ack, o.e_ack} = ack;
    {o.rd, o.wr, o.lk} = en;
    o.c1 = c1; o.aidx = aidx; o.done = dn; o.src = src;
    o.hit = ht; o.ridx = ridx; o.busy = bsy;
    return o;
  endfunction

  function automatic out_t sample();
    out_t s;
    s.i_ack = iAck; s.d_ack = dAck; s.e_ack = exeAck;
    s.rd = rdEn; s.wr = wrEn; s.lk = lookupEn; s.c1 = LookupenForEnC1;
    s.aidx = arrayIdx; s.done = done; s.src = doneSrc;
    s.hit = resHit; s.ridx = resIdx; s.busy = busy;
    return s;
  endfunction

  task automatic apply(input in_t v);
    iLookupReq = v.ireq; dLookupReq = v.dreq; exeTlbReq = v.ereq;
    exeTlbOp = v.op; exeTlbIdx = v.eidx; utlbFlush = v.flush;
    TestM3 = v.tm3; utlbHit = v.hit; utlbHitIdx = v.hidx;
  endtask

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.in = i;
    v.exp = o;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    int last_cyc;
    logic idle_seen;

    // Each vector: inputs applied for one cycle, expected outputs in the following cycle.
    // ITLB lookup hit 0x2A
    add(mi(1,0,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b100,3'b001,0,6'h00,0,2'd0,0,6'h00,1));
    add(mi(0,0,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b000,3'b000,1,6'h00,0,2'd0,0,6'h00,1));
    add(mi(0,0,0,2'b00,6'h00,0,0,1,6'h2A), mo(3'b000,3'b000,0,6'h00,1,2'd0,1,6'h2A,1));
    add(mi(0,0,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b000,3'b000,0,6'h00,0,2'd0,1,6'h2A,0));
    // exe tlbwe idx 0x05 beats a concurrent DTLB miss
    add(mi(0,1,1,2'b01,6'h05,0,0,0,6'h00), mo(3'b001,3'b010,0,6'h05,0,2'd0,1,6'h2A,1));
    add(mi(0,1,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b000,3'b000,0,6'h00,1,2'd2,0,6'h05,1));
    add(mi(0,1,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b000,3'b000,0,6'h00,0,2'd2,0,6'h05,0));
    add(mi(0,1,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b010,3'b001,0,6'h00,0,2'd2,0,6'h05,1));
    add(mi(0,0,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b000,3'b000,1,6'h00,0,2'd2,0,6'h05,1));
    add(mi(0,0,0,2'b00,6'h00,0,0,1,6'h11), mo(3'b000,3'b000,0,6'h00,1,2'd1,1,6'h11,1));
    add(mi(0,0,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b000,3'b000,0,6'h00,0,2'd1,1,6'h11,0));
    // DTLB lookup flushed in COMPARE, then flush in RESULT has no effect
    add(mi(0,1,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b010,3'b001,0,6'h00,0,2'd1,1,6'h11,1));
    add(mi(0,0,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b000,3'b000,1,6'h00,0,2'd1,1,6'h11,1));
    add(mi(0,0,0,2'b00,6'h00,1,0,1,6'h11), mo(3'b000,3'b000,0,6'h00,1,2'd1,0,6'h11,1));
    add(mi(0,0,0,2'b00,6'h00,1,0,0,6'h00), mo(3'b000,3'b000,0,6'h00,0,2'd1,0,6'h11,0));
    // ITLB lookup flushed in ACCESS
    add(mi(1,0,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b100,3'b001,0,6'h00,0,2'd1,0,6'h11,1));
    add(mi(0,0,0,2'b00,6'h00,1,0,0,6'h00), mo(3'b000,3'b000,1,6'h00,0,2'd1,0,6'h11,1));
    add(mi(0,0,0,2'b00,6'h00,0,0,1,6'h11), mo(3'b000,3'b000,0,6'h00,1,2'd0,0,6'h11,1));
    add(mi(0,0,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b000,3'b000,0,6'h00,0,2'd0,0,6'h11,0));
    // TestM3 blocks a pending tlbre, which then runs once released
    add(mi(0,0,1,2'b00,6'h3C,0,1,0,6'h00), mo(3'b000,3'b000,0,6'h00,0,2'd0,0,6'h11,0));
    add(mi(0,0,1,2'b00,6'h3C,0,1,0,6'h00), mo(3'b000,3'b000,0,6'h00,0,2'd0,0,6'h11,0));
    add(mi(0,0,1,2'b00,6'h3C,0,0,0,6'h00), mo(3'b001,3'b100,0,6'h3C,0,2'd0,0,6'h11,1));
    add(mi(0,0,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b000,3'b000,0,6'h00,1,2'd2,0,6'h3C,1));
    add(mi(0,0,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b000,3'b000,0,6'h00,0,2'd2,0,6'h3C,0));
    // TestM3 raised mid-lookup: op completes, new request stays blocked
    add(mi(0,1,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b010,3'b001,0,6'h00,0,2'd2,0,6'h3C,1));
    add(mi(0,0,0,2'b00,6'h00,0,1,0,6'h00), mo(3'b000,3'b000,1,6'h00,0,2'd2,0,6'h3C,1));
    add(mi(0,0,0,2'b00,6'h00,0,1,1,6'h15), mo(3'b000,3'b000,0,6'h00,1,2'd1,1,6'h15,1));
    add(mi(0,1,0,2'b00,6'h00,0,1,0,6'h00), mo(3'b000,3'b000,0,6'h00,0,2'd1,1,6'h15,0));
    add(mi(0,1,0,2'b00,6'h00,0,1,0,6'h00), mo(3'b000,3'b000,0,6'h00,0,2'd1,1,6'h15,0));
    add(mi(0,0,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b000,3'b000,0,6'h00,0,2'd1,1,6'h15,0));
    // exe tlbsx (arrayIdx stays 0 on a lookup)
    add(mi(0,0,1,2'b10,6'h09,0,0,0,6'h00), mo(3'b001,3'b001,0,6'h00,0,2'd1,1,6'h15,1));
    add(mi(0,0,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b000,3'b000,1,6'h00,0,2'd1,1,6'h15,1));
    add(mi(0,0,0,2'b00,6'h00,0,0,1,6'h3F), mo(3'b000,3'b000,0,6'h00,1,2'd2,1,6'h3F,1));
    add(mi(0,0,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b000,3'b000,0,6'h00,0,2'd2,1,6'h3F,0));
    // reserved op behaves as tlbsx, miss
    add(mi(0,0,1,2'b11,6'h09,0,0,0,6'h00), mo(3'b001,3'b001,0,6'h00,0,2'd2,1,6'h3F,1));
    add(mi(0,0,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b000,3'b000,1,6'h00,0,2'd2,1,6'h3F,1));
    add(mi(0,0,0,2'b00,6'h00,0,0,0,6'h22), mo(3'b000,3'b000,0,6'h00,1,2'd2,0,6'h22,1));
    add(mi(0,0,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b000,3'b000,0,6'h00,0,2'd2,0,6'h22,0));
    // DTLB beats ITLB; ITLB still held is served right after
    add(mi(1,1,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b010,3'b001,0,6'h00,0,2'd2,0,6'h22,1));
    add(mi(1,0,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b000,3'b000,1,6'h00,0,2'd2,0,6'h22,1));
    add(mi(1,0,0,2'b00,6'h00,0,0,1,6'h01), mo(3'b000,3'b000,0,6'h00,1,2'd1,1,6'h01,1));
    add(mi(1,0,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b000,3'b000,0,6'h00,0,2'd1,1,6'h01,0));
    add(mi(1,0,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b100,3'b001,0,6'h00,0,2'd1,1,6'h01,1));
    add(mi(0,0,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b000,3'b000,1,6'h00,0,2'd1,1,6'h01,1));
    add(mi(0,0,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b000,3'b000,0,6'h00,1,2'd0,0,6'h00,1));
    add(mi(0,0,0,2'b00,6'h00,0,0,0,6'h00), mo(3'b000,3'b000,0,6'h00,0,2'd0,0,6'h00,0));

    // Reset state
    repeat (3) @(posedge CB);
    #1;
    check("reset_outputs_zero", sample(), 0);
    resetN = 1'b1;

    foreach (vecs[k]) begin
      apply(vecs[k].in);
      @(posedge CB);
      #1;
      check($sformatf("vec%0d", k), sample(), vecs[k].exp);
    end

    // Starvation: ITLB held while exe and DTLB re-request every IDLE cycle
    grants   = 0;
    last_cyc = 0;
    apply(mi(1,1,1,2'b10,6'h00,0,0,0,6'h00));
    for (int cyc = 1; cyc <= 60 && grants < 5; cyc++) begin
      @(posedge CB);
      #1;
      if (iAck || dAck || exeAck) begin
        grants++;
        if (grants > 1) check($sformatf("starve_spacing%0d", grants), cyc - last_cyc, 4);
        last_cyc = cyc;
        if (grants < 5) begin
          check($sformatf("starve_grant%0d_exe", grants), {iAck, dAck, exeAck}, 3'b001);
          check($sformatf("starve_cnt%0d", grants), dut.starve_cnt_unused, grants);
        end else begin
          check("starve_grant5_itlb", {iAck, dAck, exeAck}, 3'b100);
          check("starve_cnt_cleared", dut.starve_cnt_unused, 0);
          apply(mi(0,0,0,2'b00,6'h00,0,0,0,6'h00));
        end
      end
    end
    check("starve_grants_seen", grants, 5);
    apply(mi(0,0,0,2'b00,6'h00,0,0,0,6'h00));
    idle_seen = 1'b0;
    for (int cyc = 0; cyc < 10 && !idle_seen; cyc++) begin
      @(posedge CB);
      #1;
      if (!busy) idle_seen = 1'b1;
    end
    check("starve_return_idle", idle_seen, 1);

    // Reset asserted during COMPARE of a DTLB lookup
    dLookupReq = 1'b1;
    @(posedge CB);
    #1;
    check("rst_seq_dack", {dAck, lookupEn}, 2'b11);
    @(posedge CB);
    #1;
    check("rst_seq_compare", LookupenForEnC1, 1);
    utlbHit = 1'b1;
    utlbHitIdx = 6'h2B;
    #2 resetN = 1'b0;
    #1;
    check("rst_mid_outputs_zero", sample(), 0);
    @(posedge CB);
    #1;
    check("rst_held_no_done", sample(), 0);
    resetN = 1'b1;
    utlbHit = 1'b0;
    @(posedge CB);
    #1;
    check("rst_regrant_dack", {iAck, dAck, exeAck, lookupEn, done}, 5'b01010);
    dLookupReq = 1'b0;
    @(posedge CB);
    #1;
    check("rst_regrant_compare", LookupenForEnC1, 1);
    utlbHit = 1'b1;
    @(posedge CB);
    #1;
    check("rst_regrant_done", sample(), mo(3'b000,3'b000,0,6'h00,1,2'd1,1,6'h2B,1));
    utlbHit = 1'b0;
    @(posedge CB);
    #1;
    check("rst_regrant_idle", {busy, done}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
